// File: rtl/trigger_capture_ctrl.sv
// trigger_capture_ctrl
//   Acquisition controller for a single-channel scope front end. On start it
//   arms, waits for a rising crossing of trig_level (or a forced trigger after
//   AUTO_TIMEOUT accepted samples in auto mode), then writes DEPTH decimated
//   samples to a capture RAM and pulses done.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        sequencer controls (start: 1-cycle pulse)
//   sample_valid/data   incoming ADC sample stream (8-bit unsigned)
//   trig_level          rising-edge threshold (unsigned)
//   auto_mode           force a trigger after AUTO_TIMEOUT samples
//   time_division       keep 1 of every 2^time_division samples
//   wr_en/addr/data     registered RAM write port
//   busy, done, forced  status; forced marks an auto-triggered frame
//   dbg_state           current FSM state, for observation only
//
// Handshake: a sample is consumed on any cycle with sample_valid=1 while the
// FSM is in WAIT_TRIG or CAPTURE; there is no back-pressure. A write issued
// from a sample is presented on wr_* in the following cycle, for one cycle.
module trigger_capture_ctrl #(
  parameter int DEPTH        = 160,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       sample_valid,
  input  logic [7:0] sample_data,
  input  logic [7:0] trig_level,
  input  logic       auto_mode,
  input  logic [1:0] time_division,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       forced,
  output logic [2:0] dbg_state
);

  localparam int TW = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST   = TW'(AUTO_TIMEOUT - 1);
  localparam logic [7:0]    ADDR_LAST = 8'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    WAIT_TRIG = 3'd2,
    CAPTURE   = 3'd3,
    FINISH    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    td_q, td_d;
  logic          auto_q, auto_d;
  logic [7:0]    prev_q, prev_d;
  logic          prev_valid_q, prev_valid_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic [2:0]    dec_q, dec_d;
  logic          forced_q, forced_d;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          done_q, done_d;

  logic       trig_hit;
  logic       timeout_hit;
  logic [2:0] dec_mask;
  logic [2:0] dec_inc;
  logic [7:0] addr_next;

  // Decimation period is 2^td; the counter runs modulo that period.
  always_comb begin
    dec_mask = 3'b000;
    case (td_q)
      2'd0:    dec_mask = 3'b000;
      2'd1:    dec_mask = 3'b001;
      2'd2:    dec_mask = 3'b011;
      default: dec_mask = 3'b111;
    endcase
  end

  assign dec_inc   = (dec_q + 3'd1) & dec_mask;
  assign addr_next = wr_addr_q + 8'd1;

  // Rising crossing needs a previous sample; the first one after ARM cannot fire.
  assign trig_hit    = prev_valid_q && (prev_q < trig_level) && (sample_data >= trig_level);
  assign timeout_hit = auto_q && (timeout_q == TO_LAST);

  always_comb begin
    state_d      = state_q;
    td_d         = td_q;
    auto_d       = auto_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    timeout_d    = timeout_q;
    dec_d        = dec_q;
    forced_d     = forced_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = ARM;
          td_d    = time_division;
          auto_d  = auto_mode;
        end
      end

      ARM: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d      = WAIT_TRIG;
          prev_d       = 8'd0;
          prev_valid_d = 1'b0;
          timeout_d    = '0;
          dec_d        = 3'd0;
          forced_d     = 1'b0;
        end
      end

      WAIT_TRIG: begin
        if (abort) begin
          state_d = IDLE;
        end else if (sample_valid) begin
          prev_d       = sample_data;
          prev_valid_d = 1'b1;
          if (auto_q) begin
            timeout_d = timeout_q + TW'(1);
          end
          if (trig_hit || timeout_hit) begin
            wr_en_d   = 1'b1;
            wr_addr_d = 8'd0;
            wr_data_d = sample_data;
            dec_d     = 3'd0;
            forced_d  = !trig_hit;
            state_d   = (ADDR_LAST == 8'd0) ? FINISH : CAPTURE;
          end
        end
      end

      CAPTURE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (sample_valid) begin
          dec_d = dec_inc;
          if (dec_inc == 3'd0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_next;
            wr_data_d = sample_data;
            if (addr_next == ADDR_LAST) begin
              state_d = FINISH;
            end
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
        done_d  = !abort;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      td_q         <= 2'd0;
      auto_q       <= 1'b0;
      prev_q       <= 8'd0;
      prev_valid_q <= 1'b0;
      timeout_q    <= '0;
      dec_q        <= 3'd0;
      forced_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 8'd0;
      wr_data_q    <= 8'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      td_q         <= td_d;
      auto_q       <= auto_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      timeout_q    <= timeout_d;
      dec_q        <= dec_d;
      forced_q     <= forced_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign forced    = forced_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// Directed bench for trigger_capture_ctrl: normal trigger, decimation,
// auto timeout, first-sample rule, abort and asynchronous reset.
module tb_trigger_capture_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       sample_valid;
  logic [7:0] sample_data;
  logic [7:0] trig_level;
  logic       auto_mode;
  logic [1:0] time_division;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       forced;
  logic [2:0] dbg_state;

  trigger_capture_ctrl #(.DEPTH(160), .AUTO_TIMEOUT(4096)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .trig_level    (trig_level),
    .auto_mode     (auto_mode),
    .time_division (time_division),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .forced        (forced),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- write / done log (sampled on negedge) ----------------
  int         cyc = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic [7:0] log_addr[$];
  logic [7:0] log_data[$];
  int         log_cyc[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      log_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse plus the ARM cycle; returns with the FSM in WAIT_TRIG.
  task automatic pulse_start(input logic [1:0] td, input logic am);
    time_division = td;
    auto_mode     = am;
    start         = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  // Feeds one sample per cycle (ramp or constant). Stops on budget or, if
  // stop_idle, once the FSM is back in IDLE. first = sample index whose
  // write appeared first (-1 if none). start is pulsed at sample start_at.
  task automatic feed(input logic [7:0] v0, input logic ramp, input int max_n,
                      input logic stop_idle, input int start_at,
                      output int n, output int first);
    logic [7:0] v;
    v = v0;
    n = 0;
    first = -1;
    while (n < max_n && !(stop_idle && !busy)) begin
      sample_valid = 1'b1;
      sample_data  = v;
      start        = (n == start_at);
      tick();
      n++;
      if (ramp) v = v + 8'd1;
      if (wr_en && first < 0) first = n;
    end
    sample_valid = 1'b0;
    start        = 1'b0;
  endtask

  // Verifies a full frame logged from index b: 160 writes, addr k, data v0+step*k.
  task automatic check_frame(input string tag, input int b, input logic [7:0] v0, input int step);
    int bad;
    logic [7:0] exp_d;
    bad = 0;
    check({tag, "_nwrites"}, log_addr.size() - b, 160);
    if (log_addr.size() - b == 160) begin
      for (int k = 0; k < 160; k++) begin
        exp_d = v0 + 8'(step * k);
        if (log_addr[b+k] !== 8'(k) || log_data[b+k] !== exp_d) bad++;
      end
      check({tag, "_addr0_data"}, log_data[b], v0);
      check({tag, "_last_addr"}, log_addr[b+159], 159);
    end
    check({tag, "_bad_entries"}, bad, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int first;
    int b;
    int d0;
    int bad;

    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    sample_valid = 1'b0;
    sample_data = 8'd0;
    trig_level = 8'h80;
    auto_mode = 1'b0;
    time_division = 2'd0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_forced", forced, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // T1: normal trigger on rising ramp, td=0
    b = log_addr.size(); d0 = done_cnt;
    pulse_start(2'd0, 1'b0);
    check("t1_busy_armed", busy, 1);
    feed(8'h70, 1'b1, 1000, 1'b1, -1, n, first);
    tick(); tick();
    check("t1_finished", busy, 0);
    check("t1_trigger_sample", first, 17);
    check_frame("t1", b, 8'h80, 1);
    check("t1_done_count", done_cnt - d0, 1);
    if (log_cyc.size() > 0) check("t1_done_after_last_write", done_cyc, log_cyc[log_cyc.size()-1] + 1);
    check("t1_forced", forced, 0);

    // T2: td=2; td input changed and a start pulsed while busy, both ignored
    b = log_addr.size(); d0 = done_cnt;
    pulse_start(2'd2, 1'b0);
    time_division = 2'd0;
    feed(8'h70, 1'b1, 2000, 1'b1, 100, n, first);
    tick(); tick();
    check("t2_finished", busy, 0);
    check_frame("t2", b, 8'h80, 4);
    if (log_addr.size() - b >= 3) begin
      check("t2_addr1_data", log_data[b+1], 8'h84);
      check("t2_addr2_data", log_data[b+2], 8'h88);
      bad = 0;
      for (int k = b + 1; k < log_cyc.size(); k++)
        if (log_cyc[k] - log_cyc[k-1] != 4) bad++;
      check("t2_spacing_bad", bad, 0);
    end
    check("t2_done_count", done_cnt - d0, 1);

    // T5: abort after the addr-50 write, then a normal capture
    b = log_addr.size(); d0 = done_cnt;
    pulse_start(2'd0, 1'b0);
    n = 0;
    sample_data = 8'h70;
    while (n < 400) begin
      sample_valid = 1'b1;
      tick();
      n++;
      sample_data = sample_data + 8'd1;
      if (wr_en && wr_addr == 8'd50) break;
    end
    check("t5_reached_addr50", wr_addr, 50);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy_after_abort", busy, 0);
    check("t5_no_write_after_abort", wr_en, 0);
    repeat (10) tick();
    sample_valid = 1'b0;
    check("t5_writes_total", log_addr.size() - b, 51);
    check("t5_no_done", done_cnt - d0, 0);
    b = log_addr.size(); d0 = done_cnt;
    pulse_start(2'd0, 1'b0);
    feed(8'h70, 1'b1, 1000, 1'b1, -1, n, first);
    tick(); tick();
    check_frame("t5b", b, 8'h80, 1);
    check("t5b_done_count", done_cnt - d0, 1);

    // T6: asynchronous reset in WAIT_TRIG (wr_addr/wr_data still hold 159/0x1f)
    d0 = done_cnt;
    pulse_start(2'd0, 1'b0);
    feed(8'h10, 1'b0, 5, 1'b0, -1, n, first);
    check("t6_waiting", busy, 1);
    check("t6_held_addr", wr_addr, 159);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_wr_addr", wr_addr, 0);
    check("t6_rst_wr_data", wr_data, 0);
    check("t6_rst_wr_en", wr_en, 0);
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    check("t6_start_in_reset", busy, 0);
    #3 rst_n = 1'b1;
    repeat (3) tick();
    check("t6_idle_after_reset", busy, 0);
    check("t6_no_done", done_cnt - d0, 0);

    // T4: start-cycle and ARM samples discarded; first sample cannot trigger
    b = log_addr.size();
    time_division = 2'd0;
    auto_mode = 1'b0;
    sample_valid = 1'b1; sample_data = 8'h70; start = 1'b1;
    tick();
    start = 1'b0; sample_data = 8'h7f;
    tick();
    feed(8'h90, 1'b0, 50, 1'b1, -1, n, first);
    check("t4_no_write", log_addr.size() - b, 0);
    check("t4_still_waiting", busy, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("t4_abort_idle", busy, 0);

    // T3: auto timeout with constant input
    b = log_addr.size(); d0 = done_cnt;
    pulse_start(2'd0, 1'b1);
    feed(8'h10, 1'b0, 6000, 1'b1, -1, n, first);
    tick(); tick();
    check("t3_forced_sample", first, 4096);
    check("t3_finished", busy, 0);
    check_frame("t3", b, 8'h10, 0);
    check("t3_done_count", done_cnt - d0, 1);
    check("t3_forced", forced, 1);
    repeat (10) tick();
    check("t3_forced_held", forced, 1);

    // T3b: auto_mode=0 never triggers; start clears forced
    b = log_addr.size(); d0 = done_cnt;
    pulse_start(2'd0, 1'b0);
    check("t3b_forced_cleared", forced, 0);
    feed(8'h10, 1'b0, 5000, 1'b1, -1, n, first);
    check("t3b_no_write", log_addr.size() - b, 0);
    check("t3b_still_busy", busy, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    tick();
    check("t3b_abort_idle", busy, 0);
    check("t3b_no_done", done_cnt - d0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
